// File: rtl/gate_resp_checker_pkg.sv
// ============================================================================
// Module      : gate_resp_checker_pkg
// Description : State encodings and output bit positions shared by the
//               gate-lab checker and its reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_resp_checker_pkg;

  typedef enum logic [1:0] {
    GL_IDLE = 2'd0,
    GL_RUN  = 2'd1,
    GL_DONE = 2'd2
  } gl_state_e;

  // Bit positions of the gate outputs inside the 4-bit {P,Q,R,S} word
  localparam int GL_P = 3;
  localparam int GL_Q = 2;
  localparam int GL_R = 1;
  localparam int GL_S = 0;

endpackage

`default_nettype wire

// File: rtl/gate_ref_model.sv
// ============================================================================
// Module      : gate_ref_model
// Description : Golden combinational model of the basic-gate lab outputs
//               {P,Q,R,S} = {not a, a and b, a or b, a xor b}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_ref_model
  import gate_resp_checker_pkg::*;
(
  input  logic       i0,
  input  logic       i1,
  output logic [3:0] exp
);

  always_comb begin
    exp       = '0;
    exp[GL_P] = ~i0;
    exp[GL_Q] = i0 & i1;
    exp[GL_R] = i0 | i1;
    exp[GL_S] = i0 ^ i1;
  end

endmodule

`default_nettype wire

// File: rtl/gate_resp_checker.sv
// ============================================================================
// Module      : gate_resp_checker
// Description : Bounded-session response analyser: compares observed gate
//               outputs against the reference model and accumulates results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_resp_checker
  import gate_resp_checker_pkg::*;
#(
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             i0,
  input  logic             i1,
  input  logic [3:0]       obs,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       mism_mask,
  output logic [CNT_W-1:0] fail_idx,
  output logic [5:0]       fail_vec,
  output logic             fail_seen
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] c_SAT  = '1;

  gl_state_e        r_state;
  gl_state_e        w_next;
  logic [3:0]       w_exp;
  logic [3:0]       w_diff;
  logic             w_any_mis;
  logic             w_accept;
  logic             w_restart;
  logic             w_final;
  logic [CNT_W-1:0] r_vec_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [3:0]       r_mism_mask;
  logic [CNT_W-1:0] r_fail_idx;
  logic [5:0]       r_fail_vec;
  logic             r_fail_seen;

  gate_ref_model u_ref (
    .i0  (i0),
    .i1  (i1),
    .exp (w_exp)
  );

  // Case inequality so an X/Z observation is flagged as a failure in simulation
  assign w_diff    = obs ^ w_exp;
  assign w_any_mis = (obs !== w_exp);
  assign w_accept  = in_valid && (r_state == GL_RUN);
  assign w_restart = start && (r_state != GL_RUN);
  assign w_final   = w_accept && (r_vec_cnt == c_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= GL_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      GL_IDLE: if (start)   w_next = GL_RUN;
      GL_RUN:  if (w_final) w_next = GL_DONE;
      GL_DONE: if (start)   w_next = GL_RUN;
      default:              w_next = GL_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == GL_RUN);
    busy     = (r_state == GL_RUN);
    done     = (r_state == GL_DONE);
    pass     = (r_state == GL_DONE) && (r_err_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || w_restart) begin
      r_vec_cnt   <= '0;
      r_err_cnt   <= '0;
      r_mism_mask <= '0;
      r_fail_idx  <= '0;
      r_fail_vec  <= '0;
      r_fail_seen <= 1'b0;
    end else if (w_accept) begin
      r_vec_cnt   <= r_vec_cnt + 1'b1;
      r_mism_mask <= r_mism_mask | w_diff;
      if (w_any_mis) begin
        if (r_err_cnt != c_SAT) r_err_cnt <= r_err_cnt + 1'b1;
        if (!r_fail_seen) begin
          r_fail_idx  <= r_vec_cnt;
          r_fail_vec  <= {i0, i1, obs};
          r_fail_seen <= 1'b1;
        end
      end
    end
  end

  assign vec_cnt   = r_vec_cnt;
  assign err_cnt   = r_err_cnt;
  assign mism_mask = r_mism_mask;
  assign fail_idx  = r_fail_idx;
  assign fail_vec  = r_fail_vec;
  assign fail_seen = r_fail_seen;

endmodule

`default_nettype wire

// File: tb/tb_gate_resp_checker.sv
// ============================================================================
// Module      : tb_gate_resp_checker
// Description : Scoreboard bench for gate_resp_checker; expected session
//               results are queued by stimulus and popped when done rises.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_resp_checker;

  typedef struct {
    logic       pass;
    int         err;
    int         vec;
    logic [3:0] mask;
    int         fidx;
    logic [5:0] fvec;
    logic       fseen;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, start_s = 1'b0;
  logic       in_valid = 1'b0, valid_s = 1'b0;
  logic       i0 = 1'b0, i1 = 1'b0;
  logic [3:0] obs = '0;

  logic       in_ready, busy, done, pass, fail_seen;
  logic [7:0] vec_cnt, err_cnt, fail_idx;
  logic [3:0] mism_mask;
  logic [5:0] fail_vec;

  logic       rdy_s, busy_s, done_s, pass_s, fseen_s;
  logic [1:0] vec_s, err_s, fidx_s;
  logic [3:0] mask_s;
  logic [5:0] fvec_s;

  int   total = 0;
  int   bad   = 0;
  exp_t q_a[$];
  exp_t q_s[$];
  logic done_d = 1'b0, done_s_d = 1'b0;

  always #5 clk = ~clk;

  gate_resp_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .i0(i0), .i1(i1), .obs(obs),
    .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt), .mism_mask(mism_mask),
    .fail_idx(fail_idx), .fail_vec(fail_vec), .fail_seen(fail_seen)
  );

  gate_resp_checker #(.NUM_VECTORS(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .in_valid(valid_s),
    .i0(i0), .i1(i1), .obs(obs),
    .in_ready(rdy_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .vec_cnt(vec_s), .err_cnt(err_s), .mism_mask(mask_s),
    .fail_idx(fidx_s), .fail_vec(fvec_s), .fail_seen(fseen_s)
  );

  function automatic void chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endfunction

  function automatic exp_t mk(input logic p, input int e, input int v, input logic [3:0] m,
                              input int fi, input logic [5:0] fv, input logic fs);
    exp_t r;
    r.pass = p; r.err = e; r.vec = v; r.mask = m; r.fidx = fi; r.fvec = fv; r.fseen = fs;
    return r;
  endfunction

  // Monitor: compares a queued expectation each time a session completes
  always @(negedge clk) begin
    if (done && !done_d) begin
      if (q_a.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_pass", int'(pass), int'(e.pass));
        chk("a_err_cnt", int'(err_cnt), e.err);
        chk("a_vec_cnt", int'(vec_cnt), e.vec);
        chk("a_mism_mask", int'(mism_mask), int'(e.mask));
        chk("a_fail_seen", int'(fail_seen), int'(e.fseen));
        chk("a_fail_idx", int'(fail_idx), e.fidx);
        chk("a_fail_vec", int'(fail_vec), int'(e.fvec));
        chk("a_busy_low", int'(busy), 0);
        chk("a_ready_low", int'(in_ready), 0);
      end
    end
    if (done_s && !done_s_d) begin
      if (q_s.size() == 0) chk("s_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q_s.pop_front();
        chk("s_pass", int'(pass_s), int'(e.pass));
        chk("s_err_cnt", int'(err_s), e.err);
        chk("s_vec_cnt", int'(vec_s), e.vec);
        chk("s_mism_mask", int'(mask_s), int'(e.mask));
        chk("s_fail_idx", int'(fidx_s), e.fidx);
        chk("s_fail_vec", int'(fvec_s), int'(e.fvec));
      end
    end
    done_d   = done;
    done_s_d = done_s;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic vec(input logic a, input logic b, input logic [3:0] o);
    in_valid = 1'b1; i0 = a; i1 = b; obs = o;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  task automatic clean_run();
    vec(1'b0, 1'b0, 4'b1000);
    vec(1'b0, 1'b1, 4'b1011);
    vec(1'b1, 1'b0, 4'b0011);
    vec(1'b1, 1'b1, 4'b0110);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_vec_cnt"}, int'(vec_cnt), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
    chk({tag, "_mism_mask"}, int'(mism_mask), 0);
    chk({tag, "_fail_idx"}, int'(fail_idx), 0);
    chk({tag, "_fail_vec"}, int'(fail_vec), 0);
    chk({tag, "_fail_seen"}, int'(fail_seen), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    // in_valid while idle must be ignored
    vec(1'b1, 1'b1, 4'b0000);
    vec(1'b0, 1'b0, 4'b1111);
    chk("idle_vec_cnt", int'(vec_cnt), 0);
    chk("idle_err_cnt", int'(err_cnt), 0);

    // Correct DUT
    q_a.push_back(mk(1'b1, 0, 4, 4'b0000, 0, 6'b000000, 1'b0));
    pulse_start();
    chk("run_in_ready", int'(in_ready), 1);
    chk("run_busy", int'(busy), 1);
    clean_run();

    // Faulty AND, restarted from DONE
    q_a.push_back(mk(1'b0, 1, 4, 4'b0100, 2, 6'b100111, 1'b1));
    pulse_start();
    chk("restart_done_drop", int'(done), 0);
    chk("restart_vec_clear", int'(vec_cnt), 0);
    vec(1'b0, 1'b0, 4'b1000);
    vec(1'b0, 1'b1, 4'b1011);
    vec(1'b1, 1'b0, 4'b0111);
    vec(1'b1, 1'b1, 4'b0110);

    // Two failures: first one retained
    q_a.push_back(mk(1'b0, 2, 4, 4'b1001, 0, 6'b000001, 1'b1));
    pulse_start();
    chk("restart_err_clear", int'(err_cnt), 0);
    chk("restart_fseen_clear", int'(fail_seen), 0);
    vec(1'b0, 1'b0, 4'b0001);
    vec(1'b0, 1'b1, 4'b1011);
    vec(1'b1, 1'b0, 4'b0011);
    vec(1'b1, 1'b1, 4'b0111);

    // Fresh clean run after a failing one
    q_a.push_back(mk(1'b1, 0, 4, 4'b0000, 0, 6'b000000, 1'b0));
    pulse_start();
    clean_run();

    // Gaps with a stray start mid-session: valid pattern 1,0,0,1,0,1,1
    q_a.push_back(mk(1'b1, 0, 4, 4'b0000, 0, 6'b000000, 1'b0));
    pulse_start();
    vec(1'b0, 1'b0, 4'b1000);
    idle();
    idle();
    vec(1'b0, 1'b1, 4'b1011);
    pulse_start();
    chk("midrun_start_vec_cnt", int'(vec_cnt), 2);
    chk("midrun_start_busy", int'(busy), 1);
    vec(1'b1, 1'b0, 4'b0011);
    vec(1'b1, 1'b1, 4'b0110);

    // Reset mid-session discards results
    pulse_start();
    vec(1'b0, 1'b0, 4'b0000);
    vec(1'b0, 1'b1, 4'b1011);
    chk("pre_rst_vec_cnt", int'(vec_cnt), 2);
    chk("pre_rst_mask", int'(mism_mask), 4'b1000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midrst");

    // Narrow counters: every output bit wrong on all three vectors
    q_s.push_back(mk(1'b0, 3, 3, 4'b1111, 0, 6'b000111, 1'b1));
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    valid_s = 1'b1;
    i0 = 1'b0; i1 = 1'b0; obs = 4'b0111; @(negedge clk);
    i0 = 1'b0; i1 = 1'b1; obs = 4'b0100; @(negedge clk);
    i0 = 1'b1; i1 = 1'b0; obs = 4'b1100; @(negedge clk);
    valid_s = 1'b0;

    begin
      int n;
      n = 0;
      while ((q_a.size() != 0 || q_s.size() != 0) && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("pending_sessions", q_a.size() + q_s.size(), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
